// File: rtl/pkt_wr_sched_if.sv
// Descriptor handshake and writer launch/done signals between the capture
// front end, the packet write scheduler and the DDR packet writer.
interface pkt_wr_sched_if;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_len;
    logic        wr_ctrl;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic        wr_ctrl_rdy;

    modport master (
        input  desc_valid, desc_len, wr_ctrl_rdy,
        output desc_ready, wr_ctrl, control, pkt_begin, pkt_end
    );

    modport slave (
        output desc_valid, desc_len, wr_ctrl_rdy,
        input  desc_ready, wr_ctrl, control, pkt_begin, pkt_end
    );
endinterface

// File: rtl/pkt_wr_sched.sv
// Packet write scheduler: allocates word-aligned regions in a circular capture
// buffer, launches the packet writer and commits the write pointer on done.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | disabled; captures ring geometry when enable rises
// S_WAIT_DESC | ready for a packet-length descriptor
// S_CHECK     | legality / free-space evaluation; stalls here when full
// S_START     | one-cycle writer start pulse, timeout counter loaded
// S_BUSY      | waiting for writer done or timeout
// S_COMMIT    | new write pointer visible; return to WAIT_DESC or IDLE
// S_ERROR     | writer timed out; parked until enable drops
module pkt_wr_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_PKT_BYTES  = 2048
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enable_i,
    input  logic [31:0]        buf_base_i,
    input  logic [31:0]        buf_size_i,
    input  logic [31:0]        host_rd_ptr_i,
    input  logic               drop_on_full_i,
    pkt_wr_sched_if.master     bus,
    output logic [31:0]        commit_ptr_o,
    output logic [31:0]        pkt_count_o,
    output logic [31:0]        drop_count_o,
    output logic               timeout_err_o,
    output logic               busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DESC, S_CHECK, S_START, S_BUSY, S_COMMIT, S_ERROR
    } state_t;

    // Down-counter hits zero on the cycle the up-count from the pulse reaches TIMEOUT_CYCLES-1.
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 2);
    localparam logic [31:0] MAX_LEN  = 32'(MAX_PKT_BYTES);

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] size_q, size_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] len_q, len_d;
    logic [31:0] start_q, start_d;
    logic [31:0] pkt_begin_q, pkt_begin_d;
    logic [31:0] pkt_end_q, pkt_end_d;
    logic [31:0] commit_ptr_q, commit_ptr_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] drop_count_q, drop_count_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    logic [31:0] len_r, used, free, start_c, need, end_off, wr_ptr_next;
    logic        fits_linear, illegal;

    always_comb begin
        len_r       = ({16'h0, len_q} + 32'd3) & ~32'd3;
        used        = (wr_ptr_q >= host_rd_ptr_i) ? (wr_ptr_q - host_rd_ptr_i)
                                                  : (wr_ptr_q - host_rd_ptr_i + size_q);
        free        = size_q - used - 32'd4;
        fits_linear = (wr_ptr_q + len_r) <= size_q;
        // A packet that would cross the end restarts at offset 0; the tail is skipped.
        start_c     = fits_linear ? wr_ptr_q : 32'd0;
        need        = fits_linear ? len_r : (size_q - wr_ptr_q) + len_r;
        illegal     = (len_q == 16'd0) || ({16'h0, len_q} > MAX_LEN) ||
                      (len_r > size_q - 32'd4);
        end_off     = start_q + len_r;
        wr_ptr_next = (end_off == size_q) ? 32'd0 : end_off;
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        size_d        = size_q;
        wr_ptr_d      = wr_ptr_q;
        len_d         = len_q;
        start_d       = start_q;
        pkt_begin_d   = pkt_begin_q;
        pkt_end_d     = pkt_end_q;
        commit_ptr_d  = commit_ptr_q;
        pkt_count_d   = pkt_count_q;
        drop_count_d  = drop_count_q;
        timeout_err_d = timeout_err_q;
        tmo_cnt_d     = tmo_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    base_d        = buf_base_i;
                    size_d        = buf_size_i;
                    wr_ptr_d      = 32'd0;
                    commit_ptr_d  = 32'd0;
                    timeout_err_d = 1'b0;
                    state_d       = S_WAIT_DESC;
                end
            end
            S_WAIT_DESC: begin
                if (bus.desc_valid) begin
                    len_d   = bus.desc_len;
                    state_d = S_CHECK;
                end else if (!enable_i) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (illegal || ((need > free) && drop_on_full_i)) begin
                    drop_count_d = drop_count_q + 32'd1;
                    state_d      = S_WAIT_DESC;
                end else if (need <= free) begin
                    start_d     = start_c;
                    pkt_begin_d = base_q + start_c;
                    pkt_end_d   = base_q + start_c + len_r;
                    state_d     = S_START;
                end
            end
            S_START: begin
                tmo_cnt_d = TMO_LOAD;
                state_d   = S_BUSY;
            end
            S_BUSY: begin
                // Done wins over a timeout landing on the same cycle.
                if (bus.wr_ctrl_rdy) begin
                    wr_ptr_d     = wr_ptr_next;
                    commit_ptr_d = wr_ptr_next;
                    pkt_count_d  = pkt_count_q + 32'd1;
                    state_d      = S_COMMIT;
                end else if (tmo_cnt_q == 32'd0) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 32'd1;
                end
            end
            S_COMMIT: begin
                state_d = enable_i ? S_WAIT_DESC : S_IDLE;
            end
            S_ERROR: begin
                if (!enable_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            base_q        <= 32'd0;
            size_q        <= 32'd0;
            wr_ptr_q      <= 32'd0;
            len_q         <= 16'd0;
            start_q       <= 32'd0;
            pkt_begin_q   <= 32'd0;
            pkt_end_q     <= 32'd0;
            commit_ptr_q  <= 32'd0;
            pkt_count_q   <= 32'd0;
            drop_count_q  <= 32'd0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            size_q        <= size_d;
            wr_ptr_q      <= wr_ptr_d;
            len_q         <= len_d;
            start_q       <= start_d;
            pkt_begin_q   <= pkt_begin_d;
            pkt_end_q     <= pkt_end_d;
            commit_ptr_q  <= commit_ptr_d;
            pkt_count_q   <= pkt_count_d;
            drop_count_q  <= drop_count_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.desc_ready = (state_q == S_WAIT_DESC);
    assign bus.wr_ctrl    = (state_q == S_START);
    assign bus.control    = {16'h0, len_q};
    assign bus.pkt_begin  = pkt_begin_q;
    assign bus.pkt_end    = pkt_end_q;
    assign commit_ptr_o   = commit_ptr_q;
    assign pkt_count_o    = pkt_count_q;
    assign drop_count_o   = drop_count_q;
    assign timeout_err_o  = timeout_err_q;
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_WAIT_DESC);

endmodule
